// File: rtl/acc_seq_ctrl.sv
// Multi-cycle sequencer for a tiny accumulator machine: fetch, decode, execute.
// Drives the instruction memory, ALU strobes and pc; flags come back from an external flag block.
module acc_seq_ctrl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       instr,
  input  logic              zf,
  input  logic              sf,
  input  logic              cy,
  input  logic              ov,
  output logic [ADDR_W-1:0] pc,
  output logic              imem_re,
  output logic [1:0]        alu_op,
  output logic [WIDTH-1:0]  operand,
  output logic              acc_we,
  output logic              ce_cy,
  output logic              halted,
  output logic              illegal
);

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_JNZ = 4'h7;
  localparam logic [3:0] OP_JC  = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JV  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] ALU_PASS = 2'b00;
  localparam logic [1:0] ALU_ADD  = 2'b01;
  localparam logic [1:0] ALU_SUB  = 2'b10;
  localparam logic [1:0] ALU_AND  = 2'b11;

  // Jump target comes from the 8-bit immediate field, zero-extended to the pc width.
  localparam int unsigned TGT_W = (ADDR_W < 8) ? ADDR_W : 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t              state;
  logic [15:0]         ir;
  logic                dec_we;
  logic                dec_ce;
  logic [1:0]          dec_op;
  logic                take;
  logic                is_hlt;
  logic                is_ill;
  logic [ADDR_W-1:0]   jmp_tgt;
  logic [ADDR_W-1:0]   pc_next;
  logic                unused_ir;

  assign operand   = ir[WIDTH-1:0];
  assign jmp_tgt   = ADDR_W'(ir[TGT_W-1:0]);
  assign unused_ir = ^ir[11:0];

  // Strobe decode from the incoming word so EXEC strobes can be registered.
  always_comb begin
    dec_we = 1'b0;
    dec_ce = 1'b0;
    dec_op = ALU_PASS;
    case (instr[15:12])
      OP_LDI: dec_we = 1'b1;
      OP_ADD: begin
        dec_we = 1'b1;
        dec_ce = 1'b1;
        dec_op = ALU_ADD;
      end
      OP_SUB: begin
        dec_we = 1'b1;
        dec_ce = 1'b1;
        dec_op = ALU_SUB;
      end
      OP_AND: begin
        dec_we = 1'b1;
        dec_op = ALU_AND;
      end
      default: ;
    endcase
  end

  // Control-flow resolution on the held IR and the flags present during EXEC.
  always_comb begin
    take   = 1'b0;
    is_hlt = 1'b0;
    is_ill = 1'b0;
    case (ir[15:12])
      OP_JMP:                   take   = 1'b1;
      OP_JZ:                    take   = zf;
      OP_JNZ:                   take   = ~zf;
      OP_JC:                    take   = cy;
      OP_JN:                    take   = sf;
      OP_JV:                    take   = ov;
      OP_HLT:                   is_hlt = 1'b1;
      4'hB, 4'hC, 4'hD, 4'hE:   is_ill = 1'b1;
      default: ;
    endcase
    pc_next = take ? jmp_tgt : pc + ADDR_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir      <= '0;
      imem_re <= 1'b0;
      acc_we  <= 1'b0;
      ce_cy   <= 1'b0;
      alu_op  <= ALU_PASS;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      imem_re <= 1'b0;
      acc_we  <= 1'b0;
      ce_cy   <= 1'b0;
      alu_op  <= ALU_PASS;
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state   <= S_FETCH;
            pc      <= '0;
            illegal <= 1'b0;
            halted  <= 1'b0;
            imem_re <= 1'b1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir     <= instr;
          acc_we <= dec_we;
          ce_cy  <= dec_ce;
          alu_op <= dec_op;
          state  <= S_EXEC;
        end
        S_EXEC: begin
          if (is_hlt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else begin
            pc      <= pc_next;
            imem_re <= 1'b1;
            state   <= S_FETCH;
            if (is_ill) illegal <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
